// File: rtl/spi_reg_controller.sv
// spi_reg_controller: turns the SPI byte stream (command + burst data) into a register file.
// Optional build macro SPI_REG_ERRCNT_EN adds a saturating error counter at address 7'h7F.
`default_nettype none

module spi_reg_controller #(
  parameter int          NUM_REGS  = 8,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ss_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  output logic [7:0]            tx_byte_o,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_strobe_o,
  output logic [6:0]            wr_addr_o,
  output logic                  busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;

  localparam logic [7:0] C_NREGS = 8'(NUM_REGS);
  localparam logic [6:0] C_LAST  = 7'(NUM_REGS - 1);

  logic       ss_meta_q, ss_s_q;
  logic [1:0] state_q, state_d;
  logic [6:0] ptr_q, ptr_d;
  logic [7:0] tx_q, tx_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic       we;
  logic [7:0] regs_q [NUM_REGS];

`ifdef SPI_REG_ERRCNT_EN
  localparam logic [6:0] C_ERR_ADDR = 7'h7F;
  logic [7:0] errcnt_q, errcnt_d;
  logic       err_inc, err_clr;
`endif

  function automatic logic [6:0] nxt(input logic [6:0] p);
    return (p == C_LAST) ? 7'd0 : p + 7'd1;
  endfunction

  function automatic logic in_range(input logic [6:0] p);
    return {1'b0, p} < C_NREGS;
  endfunction

  function automatic logic rd_oor(input logic [6:0] p);
`ifdef SPI_REG_ERRCNT_EN
    return !in_range(p) && (p != C_ERR_ADDR);
`else
    return !in_range(p);
`endif
  endfunction

  function automatic logic [7:0] rd_data(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == 7'(i)) v = regs_q[i];
    end
`ifdef SPI_REG_ERRCNT_EN
    if (a == C_ERR_ADDR) v = errcnt_q;
`endif
    return v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ss_meta_q <= 1'b1;
      ss_s_q    <= 1'b1;
    end else begin
      ss_meta_q <= ss_i;
      ss_s_q    <= ss_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!ss_s_q) state_d = S_CMD;
      S_CMD: begin
        if (ss_s_q)          state_d = S_IDLE;
        else if (rx_valid_i) state_d = rx_byte_i[7] ? S_WR : S_RD;
      end
      default: if (ss_s_q) state_d = S_IDLE;
    endcase
  end

  // A byte arriving with the ss release is still processed; only tx is forced to 0 on exit.
  always_comb begin
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    we          = 1'b0;
`ifdef SPI_REG_ERRCNT_EN
    err_inc     = 1'b0;
    err_clr     = 1'b0;
`endif
    if (rx_valid_i) begin
      case (state_q)
        S_CMD: begin
          ptr_d = rx_byte_i[6:0];
          if (!rx_byte_i[7]) begin
            tx_d = rd_data(rx_byte_i[6:0]);
`ifdef SPI_REG_ERRCNT_EN
            err_inc = rd_oor(rx_byte_i[6:0]);
`endif
          end
        end
        S_WR: begin
          ptr_d = nxt(ptr_q);
          if (in_range(ptr_q)) begin
            we          = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
          end
`ifdef SPI_REG_ERRCNT_EN
          else if (ptr_q == C_ERR_ADDR) err_clr = 1'b1;
          else                          err_inc = 1'b1;
`endif
        end
        S_RD: begin
          ptr_d = nxt(ptr_q);
          tx_d  = rd_data(nxt(ptr_q));
`ifdef SPI_REG_ERRCNT_EN
          err_inc = rd_oor(nxt(ptr_q));
`endif
        end
        default: ;
      endcase
    end
    if (state_q != S_IDLE && ss_s_q) tx_d = 8'h00;
  end

`ifdef SPI_REG_ERRCNT_EN
  always_comb begin
    errcnt_d = errcnt_q;
    if (err_clr)                          errcnt_d = 8'h00;
    else if (err_inc && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) errcnt_q <= 8'h00;
    else         errcnt_q <= errcnt_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= 7'd0;
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
    end else begin
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ptr_q == 7'(i)) regs_q[i] <= rx_byte_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[8*g +: 8] = regs_q[g];
  end

  assign tx_byte_o   = tx_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: directed checks of bursts, wrap, out-of-range, abort, reset for NUM_REGS=8.
`default_nettype none

module tb_spi_reg_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [63:0] regs;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  spi_reg_controller #(.NUM_REGS(8), .RESET_VAL(8'h00)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ss_i        (ss),
    .rx_valid_i  (rx_valid),
    .rx_byte_i   (rx_byte),
    .tx_byte_o   (tx_byte),
    .regs_o      (regs),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ss_start();
    ss = 1'b0;
    repeat (4) tick();
  endtask

  task automatic ss_end();
    ss = 1'b1;
    repeat (4) tick();
  endtask

  // Leaves the caller just after the edge that consumed the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (regs !== 64'h0) begin n_fail++; $display("FAIL rst_regs: got %h exp %h", regs, 64'h0); end
    n_chk++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_tx: got %h exp %h", tx_byte, 8'h00); end
    n_chk++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %b exp 0", wr_strobe); end
    n_chk++; if (wr_addr !== 7'h00) begin n_fail++; $display("FAIL rst_addr: got %h exp 00", wr_addr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
  endtask

  task automatic test_write_burst();
    ss_start();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b exp 1", busy); end
    send_byte(8'h82); tick();
    n_chk++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL wr_cmd_strobe: got %b exp 0", wr_strobe); end
    send_byte(8'hAA);
    n_chk++; if (wr_strobe !== 1'b1 || wr_addr !== 7'd2) begin n_fail++; $display("FAIL wr_strobe0: got %b/%h exp 1/02", wr_strobe, wr_addr); end
    tick();
    n_chk++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_pulse: got %b exp 0", wr_strobe); end
    send_byte(8'h55);
    n_chk++; if (wr_strobe !== 1'b1 || wr_addr !== 7'd3) begin n_fail++; $display("FAIL wr_strobe1: got %b/%h exp 1/03", wr_strobe, wr_addr); end
    ss_end();
    n_chk++; if (regs !== 64'h00000000_55AA0000) begin n_fail++; $display("FAIL wr_regs: got %h exp %h", regs, 64'h00000000_55AA0000); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_end_busy: got %b exp 0", busy); end
  endtask

  task automatic test_read_burst();
    ss_start(); send_byte(8'h80); send_byte(8'h11); send_byte(8'h22); ss_end();
    ss_start();
    send_byte(8'h00); tick();
    n_chk++; if (tx_byte !== 8'h11) begin n_fail++; $display("FAIL rd_tx0: got %h exp 11", tx_byte); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy0: got %b exp 1", busy); end
    send_byte(8'hFF); tick();
    n_chk++; if (tx_byte !== 8'h22) begin n_fail++; $display("FAIL rd_tx1: got %h exp 22", tx_byte); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy1: got %b exp 1", busy); end
    send_byte(8'hFF); tick();
    n_chk++; if (tx_byte !== 8'hAA) begin n_fail++; $display("FAIL rd_tx2: got %h exp AA", tx_byte); end
    ss_end();
    n_chk++; if (tx_byte !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_end: got tx %h busy %b exp 00/0", tx_byte, busy); end
  endtask

  task automatic test_wrap();
    ss_start();
    send_byte(8'h87);
    send_byte(8'h01);
    n_chk++; if (wr_strobe !== 1'b1 || wr_addr !== 7'd7) begin n_fail++; $display("FAIL wrap_addr7: got %b/%h exp 1/07", wr_strobe, wr_addr); end
    send_byte(8'h02);
    n_chk++; if (wr_strobe !== 1'b1 || wr_addr !== 7'd0) begin n_fail++; $display("FAIL wrap_addr0: got %b/%h exp 1/00", wr_strobe, wr_addr); end
    ss_end();
    n_chk++; if (regs !== 64'h01000000_55AA2202) begin n_fail++; $display("FAIL wrap_regs: got %h exp %h", regs, 64'h01000000_55AA2202); end
    ss_start();
    send_byte(8'h07); tick();
    n_chk++; if (tx_byte !== 8'h01) begin n_fail++; $display("FAIL wrap_rd7: got %h exp 01", tx_byte); end
    send_byte(8'hFF); tick();
    n_chk++; if (tx_byte !== 8'h02) begin n_fail++; $display("FAIL wrap_rd0: got %h exp 02", tx_byte); end
    ss_end();
  endtask

  task automatic test_out_of_range();
    ss_start();
    send_byte(8'h8A);
    send_byte(8'hFF);
    n_chk++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL oor_strobe: got %b exp 0", wr_strobe); end
    ss_end();
    n_chk++; if (regs !== 64'h01000000_55AA2202) begin n_fail++; $display("FAIL oor_regs: got %h exp %h", regs, 64'h01000000_55AA2202); end
    ss_start();
    send_byte(8'h0A); tick();
    n_chk++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL oor_rd: got %h exp 00", tx_byte); end
    ss_end();
    ss_start();
    send_byte(8'h7F); tick();
`ifdef SPI_REG_ERRCNT_EN
    n_chk++; if (tx_byte !== 8'h02) begin n_fail++; $display("FAIL errcnt_rd: got %h exp 02", tx_byte); end
`else
    n_chk++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL rd_7f: got %h exp 00", tx_byte); end
`endif
    ss_end();
    // Start at 7'h7F: one dropped byte, then the pointer wraps to reg0.
    ss_start();
    send_byte(8'hFF);
    send_byte(8'h33);
    n_chk++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL hi_wrap_drop: got %b exp 0", wr_strobe); end
    send_byte(8'h44);
    n_chk++; if (wr_strobe !== 1'b1 || wr_addr !== 7'd0) begin n_fail++; $display("FAIL hi_wrap_addr: got %b/%h exp 1/00", wr_strobe, wr_addr); end
    ss_end();
`ifdef SPI_REG_ERRCNT_EN
    ss_start();
    send_byte(8'h7F); tick();
    n_chk++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL errcnt_clr: got %h exp 00", tx_byte); end
    ss_end();
`endif
    n_chk++; if (regs !== 64'h01000000_55AA2244) begin n_fail++; $display("FAIL hi_wrap_regs: got %h exp %h", regs, 64'h01000000_55AA2244); end
  endtask

  task automatic test_abort();
    ss_start();
    send_byte(8'h83);
    ss_end();
    n_chk++; if (regs !== 64'h01000000_55AA2244) begin n_fail++; $display("FAIL abort_regs: got %h exp %h", regs, 64'h01000000_55AA2244); end
    n_chk++; if (busy !== 1'b0 || tx_byte !== 8'h00) begin n_fail++; $display("FAIL abort_idle: got busy %b tx %h exp 0/00", busy, tx_byte); end
  endtask

  task automatic test_simultaneous_end();
    ss_start();
    send_byte(8'h84);
    ss = 1'b1;
    tick(); tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy_pre: got %b exp 1", busy); end
    send_byte(8'h77);
    n_chk++; if (wr_strobe !== 1'b1 || wr_addr !== 7'd4) begin n_fail++; $display("FAIL sim_strobe: got %b/%h exp 1/04", wr_strobe, wr_addr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_busy_post: got %b exp 0", busy); end
    repeat (2) tick();
    n_chk++; if (regs !== 64'h01000077_55AA2244) begin n_fail++; $display("FAIL sim_regs: got %h exp %h", regs, 64'h01000077_55AA2244); end
  endtask

  task automatic test_reset_midframe();
    ss_start();
    send_byte(8'h81);
    send_byte(8'h99);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (regs !== 64'h0) begin n_fail++; $display("FAIL mid_rst_regs: got %h exp %h", regs, 64'h0); end
    n_chk++; if (wr_strobe !== 1'b0 || wr_addr !== 7'd0) begin n_fail++; $display("FAIL mid_rst_wr: got %b/%h exp 0/00", wr_strobe, wr_addr); end
    n_chk++; if (busy !== 1'b0 || tx_byte !== 8'h00) begin n_fail++; $display("FAIL mid_rst_st: got busy %b tx %h exp 0/00", busy, tx_byte); end
    ss = 1'b1;
    #2 rst_n = 1'b1;
    repeat (3) tick();
    n_chk++; if (busy !== 1'b0 || regs !== 64'h0) begin n_fail++; $display("FAIL post_rst: got busy %b regs %h exp 0/0", busy, regs); end
  endtask

  initial begin
    rst_n    = 1'b0;
    ss       = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    #3;
    test_reset();
    #19 rst_n = 1'b1;
    tick();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_out_of_range();
    test_abort();
    test_simultaneous_end();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
